// File: rtl/alu_scrub_arbiter.sv
// alu_scrub_arbiter: arbitrates the shared redundant ALU between datapath
// requests and a built-in scrubber. The scrubber issues golden vectors after
// IDLE_THRESH idle cycles, checks the voted result, and keeps a sticky fault
// flag plus a saturating mismatch counter.
// Optional feature macro: ALU_SCRUB_LOG_EN adds last_fail_idx/last_fail_result.
module alu_scrub_arbiter #(
   parameter int unsigned IDLE_THRESH = 16,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic [31:0]          req_a,
   input  logic [31:0]          req_b,
   input  logic [2:0]           req_alucont,
   output logic                 req_ready,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_result,
   output logic                 rsp_zero,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [2:0]           alu_alucont,
   input  logic [31:0]          alu_result,
   input  logic                 alu_zero,
   input  logic                 scrub_en,
   input  logic                 fault_clr,
   output logic                 scrub_busy,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] fault_count
`ifdef ALU_SCRUB_LOG_EN
   ,
   output logic [2:0]           last_fail_idx,
   output logic [31:0]          last_fail_result
`endif
);

   localparam int unsigned    IC_W   = (IDLE_THRESH > 1) ? $clog2(IDLE_THRESH) : 1;
   localparam logic [IC_W-1:0] IC_MAX = IC_W'(IDLE_THRESH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DP_EXEC,
      S_SCRUB_ISSUE,
      S_SCRUB_CHECK
   } state_e;

   state_e                state_q, state_d;
   logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
   logic [2:0]            vec_idx_q, vec_idx_d;
   logic [31:0]           alu_a_q, alu_a_d;
   logic [31:0]           alu_b_q, alu_b_d;
   logic [2:0]            alu_alucont_q, alu_alucont_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_result_q, rsp_result_d;
   logic                  rsp_zero_q, rsp_zero_d;
   logic                  fault_q, fault_d;
   logic [CNT_WIDTH-1:0]  fault_count_q, fault_count_d;
   logic                  mismatch;

   logic [31:0]           gold_a, gold_b, gold_res;
   logic [2:0]            gold_c;
   logic                  gold_zero;

   // Golden vector table indexed by the current scrub vector
   always_comb begin
      gold_a    = '0;
      gold_b    = '0;
      gold_c    = '0;
      gold_res  = '0;
      gold_zero = 1'b0;
      case (vec_idx_q)
         3'd0: begin gold_a = 32'd5;         gold_b = 32'd3;         gold_c = 3'b010; gold_res = 32'd8;         gold_zero = 1'b0; end
         3'd1: begin gold_a = 32'd5;         gold_b = 32'd5;         gold_c = 3'b110; gold_res = 32'd0;         gold_zero = 1'b1; end
         3'd2: begin gold_a = 32'hF0F0F0F0;  gold_b = 32'hFF00FF00;  gold_c = 3'b000; gold_res = 32'hF000F000;  gold_zero = 1'b0; end
         3'd3: begin gold_a = 32'h0F0F0F0F;  gold_b = 32'hF0F0F0F0;  gold_c = 3'b001; gold_res = 32'hFFFFFFFF;  gold_zero = 1'b0; end
         3'd4: begin gold_a = 32'd3;         gold_b = 32'd5;         gold_c = 3'b111; gold_res = 32'd1;         gold_zero = 1'b0; end
         3'd5: begin gold_a = 32'd5;         gold_b = 32'd3;         gold_c = 3'b111; gold_res = 32'd0;         gold_zero = 1'b1; end
         3'd6: begin gold_a = 32'hFFFFFFFF;  gold_b = 32'd1;         gold_c = 3'b010; gold_res = 32'd0;         gold_zero = 1'b1; end
         default: begin gold_a = 32'h80000000; gold_b = 32'd1;      gold_c = 3'b110; gold_res = 32'h7FFFFFFF;  gold_zero = 1'b0; end
      endcase
   end

   // Next-state, operand mux, idle counting and response capture
   always_comb begin
      state_d       = state_q;
      idle_cnt_d    = idle_cnt_q;
      vec_idx_d     = vec_idx_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_alucont_d = alu_alucont_q;
      rsp_valid_d   = 1'b0;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      mismatch      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               alu_a_d       = req_a;
               alu_b_d       = req_b;
               alu_alucont_d = req_alucont;
               idle_cnt_d    = '0;
               state_d       = S_DP_EXEC;
            end else if (scrub_en && (idle_cnt_q == IC_MAX)) begin
               alu_a_d       = gold_a;
               alu_b_d       = gold_b;
               alu_alucont_d = gold_c;
               state_d       = S_SCRUB_ISSUE;
            end else if (idle_cnt_q != IC_MAX) begin
               idle_cnt_d = idle_cnt_q + IC_W'(1);
            end
         end
         S_DP_EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_valid_d  = 1'b1;
            state_d      = S_IDLE;
         end
         S_SCRUB_ISSUE: begin
            state_d = S_SCRUB_CHECK;
         end
         S_SCRUB_CHECK: begin
            mismatch   = ({alu_result, alu_zero} != {gold_res, gold_zero});
            vec_idx_d  = vec_idx_q + 3'd1;
            idle_cnt_d = '0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky fault and saturating count; a mismatch overrides a same-cycle clear
   always_comb begin
      fault_d       = fault_q;
      fault_count_d = fault_count_q;
      if (fault_clr) begin
         fault_d       = 1'b0;
         fault_count_d = '0;
      end
      if (mismatch) begin
         fault_d = 1'b1;
         if (fault_clr) begin
            fault_count_d = CNT_WIDTH'(1);
         end else if (fault_count_q != '1) begin
            fault_count_d = fault_count_q + CNT_WIDTH'(1);
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idle_cnt_q    <= '0;
         vec_idx_q     <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_alucont_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         fault_q       <= 1'b0;
         fault_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idle_cnt_q    <= idle_cnt_d;
         vec_idx_q     <= vec_idx_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_alucont_q <= alu_alucont_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         fault_q       <= fault_d;
         fault_count_q <= fault_count_d;
      end
   end

`ifdef ALU_SCRUB_LOG_EN
   logic [2:0]  last_fail_idx_q, last_fail_idx_d;
   logic [31:0] last_fail_result_q, last_fail_result_d;

   // Record the vector index and result of the latest mismatch
   always_comb begin
      last_fail_idx_d    = last_fail_idx_q;
      last_fail_result_d = last_fail_result_q;
      if (mismatch) begin
         last_fail_idx_d    = vec_idx_q;
         last_fail_result_d = alu_result;
      end
   end

   // Failure log registers; unaffected by fault_clr
   always_ff @(posedge clk) begin
      if (reset) begin
         last_fail_idx_q    <= '0;
         last_fail_result_q <= '0;
      end else begin
         last_fail_idx_q    <= last_fail_idx_d;
         last_fail_result_q <= last_fail_result_d;
      end
   end

   assign last_fail_idx    = last_fail_idx_q;
   assign last_fail_result = last_fail_result_q;
`endif

   assign req_ready   = (state_q == S_IDLE);
   assign scrub_busy  = (state_q == S_SCRUB_ISSUE) || (state_q == S_SCRUB_CHECK);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_zero    = rsp_zero_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_alucont = alu_alucont_q;
   assign fault       = fault_q;
   assign fault_count = fault_count_q;

endmodule

// File: tb/tb_alu_scrub_arbiter.sv
// tb_alu_scrub_arbiter: environment ALU with fault injection, a transaction
// level reference model, a per-cycle compare process, directed scenarios
// with literal expectations, then randomized traffic.
module tb_alu_scrub_arbiter;

   localparam int THRESH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_a, req_b;
   logic [2:0]  req_alucont;
   logic        req_ready, rsp_valid, rsp_zero;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic [2:0]  alu_alucont;
   logic        alu_zero;
   logic        scrub_en, fault_clr, scrub_busy, fault;
   logic [7:0]  fault_count;
   logic        inj_force0;
   logic [31:0] inj_xor;
`ifdef ALU_SCRUB_LOG_EN
   logic [2:0]  last_fail_idx;
   logic [31:0] last_fail_result;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_scrub_arbiter #(.IDLE_THRESH(THRESH), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_alucont(req_alucont),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_alucont(alu_alucont),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .scrub_en(scrub_en), .fault_clr(fault_clr), .scrub_busy(scrub_busy),
      .fault(fault), .fault_count(fault_count)
`ifdef ALU_SCRUB_LOG_EN
      , .last_fail_idx(last_fail_idx), .last_fail_result(last_fail_result)
`endif
   );

   // Environment ALU: true result optionally corrupted; zero flag reflects the true result
   function automatic logic [32:0] alu_env(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c, input logic f0, input logic [31:0] x);
      logic [31:0] r;
      case (c)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b100:  r = a & ~b;
         3'b101:  r = a | ~b;
         3'b110:  r = a - b;
         3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return {(f0 ? 32'd0 : (r ^ x)), (r == 32'd0)};
   endfunction

   assign {alu_result, alu_zero} = alu_env(alu_a, alu_b, alu_alucont, inj_force0, inj_xor);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Golden table as written in the block description
   logic [31:0] g_a[8], g_b[8], g_res[8];
   logic [2:0]  g_c[8];
   logic        g_zero[8];
   initial begin
      g_a[0]=32'd5;        g_b[0]=32'd5-32'd2;   g_c[0]=3'b010; g_res[0]=32'd8;        g_zero[0]=1'b0;
      g_a[1]=32'd5;        g_b[1]=32'd5;         g_c[1]=3'b110; g_res[1]=32'd0;        g_zero[1]=1'b1;
      g_a[2]=32'hF0F0F0F0; g_b[2]=32'hFF00FF00;  g_c[2]=3'b000; g_res[2]=32'hF000F000; g_zero[2]=1'b0;
      g_a[3]=32'h0F0F0F0F; g_b[3]=32'hF0F0F0F0;  g_c[3]=3'b001; g_res[3]=32'hFFFFFFFF; g_zero[3]=1'b0;
      g_a[4]=32'd3;        g_b[4]=32'd5;         g_c[4]=3'b111; g_res[4]=32'd1;        g_zero[4]=1'b0;
      g_a[5]=32'd5;        g_b[5]=32'd3;         g_c[5]=3'b111; g_res[5]=32'd0;        g_zero[5]=1'b1;
      g_a[6]=32'hFFFFFFFF; g_b[6]=32'd1;         g_c[6]=3'b010; g_res[6]=32'd0;        g_zero[6]=1'b1;
      g_a[7]=32'h80000000; g_b[7]=32'd1;         g_c[7]=3'b110; g_res[7]=32'h7FFFFFFF; g_zero[7]=1'b0;
   end

   // Reference model: a job (0 none, 1 datapath, 2 scrub) finishes at a known edge number
   int          edge_no = 0;
   int          job = 0;
   int          done_edge = 0;
   int          m_idle = 0;
   int          m_vec = 0;
   int          e_count = 0;
   logic        e_fault = 1'b0, e_rsp_valid = 1'b0, e_rsp_zero = 1'b0;
   logic [31:0] e_rsp_result = '0, e_alu_a = '0, e_alu_b = '0;
   logic [2:0]  e_alu_c = '0;
   logic [2:0]  e_lf_idx = '0;
   logic [31:0] e_lf_res = '0;

   always @(posedge clk) begin
      logic [32:0] got;
      logic        mism;
      edge_no++;
      mism = 1'b0;
      e_rsp_valid = 1'b0;
      if (reset) begin
         job = 0; m_idle = 0; m_vec = 0; e_count = 0; e_fault = 1'b0;
         e_rsp_result = '0; e_rsp_zero = 1'b0;
         e_alu_a = '0; e_alu_b = '0; e_alu_c = '0;
         e_lf_idx = '0; e_lf_res = '0;
      end else begin
         got = alu_env(e_alu_a, e_alu_b, e_alu_c, inj_force0, inj_xor);
         if (job != 0 && edge_no == done_edge) begin
            if (job == 1) begin
               e_rsp_result = got[32:1];
               e_rsp_zero   = got[0];
               e_rsp_valid  = 1'b1;
            end else begin
               mism = (got != {g_res[m_vec], g_zero[m_vec]});
               if (mism) begin
                  e_lf_idx = 3'(m_vec);
                  e_lf_res = got[32:1];
               end
               m_vec  = (m_vec + 1) % 8;
               m_idle = 0;
            end
            job = 0;
         end else if (job == 0) begin
            if (req_valid) begin
               e_alu_a = req_a; e_alu_b = req_b; e_alu_c = req_alucont;
               job = 1; done_edge = edge_no + 1; m_idle = 0;
            end else if (scrub_en && m_idle == THRESH - 1) begin
               e_alu_a = g_a[m_vec]; e_alu_b = g_b[m_vec]; e_alu_c = g_c[m_vec];
               job = 2; done_edge = edge_no + 2;
            end else if (m_idle < THRESH - 1) begin
               m_idle++;
            end
         end
         if (mism) begin
            e_fault = 1'b1;
            e_count = fault_clr ? 1 : ((e_count >= 255) ? 255 : e_count + 1);
         end else if (fault_clr) begin
            e_fault = 1'b0;
            e_count = 0;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      chk("req_ready",   32'(req_ready),   32'(job == 0));
      chk("scrub_busy",  32'(scrub_busy),  32'(job == 2));
      chk("rsp_valid",   32'(rsp_valid),   32'(e_rsp_valid));
      chk("rsp_result",  rsp_result,       e_rsp_result);
      chk("rsp_zero",    32'(rsp_zero),    32'(e_rsp_zero));
      chk("alu_a",       alu_a,            e_alu_a);
      chk("alu_b",       alu_b,            e_alu_b);
      chk("alu_alucont", 32'(alu_alucont), 32'(e_alu_c));
      chk("fault",       32'(fault),       32'(e_fault));
      chk("fault_count", 32'(fault_count), 32'(e_count));
`ifdef ALU_SCRUB_LOG_EN
      chk("last_fail_idx",    32'(last_fail_idx), 32'(e_lf_idx));
      chk("last_fail_result", last_fail_result,   e_lf_res);
`endif
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      int first, nbusy, rises, k;
      logic prev;
      reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_alucont = '0;
      scrub_en = 1'b0; fault_clr = 1'b0; inj_force0 = 1'b0; inj_xor = '0;
      cyc(); cyc();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rspv",  32'(rsp_valid), 32'd0);
      chk("rst_count", 32'(fault_count), 32'd0);
      reset = 1'b0;

      // Single datapath op: 7 - 2
      req_valid = 1'b1; req_a = 32'd7; req_b = 32'd2; req_alucont = 3'b110;
      cyc();
      req_valid = 1'b0;
      chk("dp_busy_ready", 32'(req_ready), 32'd0);
      chk("dp_busy_rspv",  32'(rsp_valid), 32'd0);
      cyc();
      chk("dp_rspv",   32'(rsp_valid),  32'd1);
      chk("dp_result", rsp_result,      32'd5);
      chk("dp_zero",   32'(rsp_zero),   32'd0);
      cyc();
      chk("dp_pulse",  32'(rsp_valid),  32'd0);
      chk("dp_hold",   rsp_result,      32'd5);

      // Healthy scrub after 16 idle cycles
      do_reset();
      scrub_en = 1'b1; first = -1; nbusy = 0;
      for (int i = 1; i <= 18; i++) begin
         cyc();
         if (scrub_busy) begin
            nbusy++;
            if (first < 0) first = i;
         end
         if (i == 16) chk("scrub_vec0_a", alu_a, 32'd5);
      end
      scrub_en = 1'b0;
      chk("scrub_first", 32'(first), 32'd16);
      chk("scrub_len",   32'(nbusy), 32'd2);
      chk("scrub_ok",    32'(fault), 32'd0);

      // Forced zero result during vector 0 check
      do_reset();
      inj_force0 = 1'b1; scrub_en = 1'b1;
      repeat (18) cyc();
      scrub_en = 1'b0; inj_force0 = 1'b0;
      chk("inj_fault", 32'(fault),       32'd1);
      chk("inj_count", 32'(fault_count), 32'd1);
      fault_clr = 1'b1;
      cyc();
      fault_clr = 1'b0;
      chk("clr_fault", 32'(fault),       32'd0);
      chk("clr_count", 32'(fault_count), 32'd0);

      // Request arriving on the threshold cycle wins; scrub deferred
      do_reset();
      scrub_en = 1'b1;
      repeat (15) cyc();
      req_valid = 1'b1; req_a = 32'd9; req_b = 32'd4; req_alucont = 3'b010;
      cyc();
      req_valid = 1'b0;
      chk("tie_busy",  32'(scrub_busy), 32'd0);
      chk("tie_alu_a", alu_a,           32'd9);
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 1) chk("tie_result", rsp_result, 32'd13);
         if (scrub_busy && first < 0) first = i;
      end
      scrub_en = 1'b0;
      chk("tie_defer", 32'(first), 32'd17);

      // Nine back-to-back scrubs wrap the vector index
      do_reset();
      scrub_en = 1'b1; rises = 0; prev = 1'b0; k = 0;
      while (rises < 9 && k < 400) begin
         cyc();
         k++;
         if (scrub_busy && !prev) begin
            rises++;
            if (rises == 8) chk("wrap_vec7_a", alu_a, 32'h80000000);
            if (rises == 9) chk("wrap_vec0_b", alu_b, 32'd3);
         end
         prev = scrub_busy;
      end
      scrub_en = 1'b0;
      chk("wrap_rises", 32'(rises), 32'd9);
      repeat (3) cyc();
      chk("wrap_fault", 32'(fault), 32'd0);

      // Counter saturation, then clear coinciding with a mismatch
      do_reset();
      inj_xor = 32'h1; scrub_en = 1'b1;
      repeat (260 * 18) cyc();
      chk("sat_count", 32'(fault_count), 32'hFF);
      k = 0;
      while (scrub_busy && k < 40) begin cyc(); k++; end
      while (!scrub_busy && k < 80) begin cyc(); k++; end
      chk("clrmis_wait", 32'(scrub_busy), 32'd1);
      cyc();
      fault_clr = 1'b1;
      cyc();
      fault_clr = 1'b0; scrub_en = 1'b0; inj_xor = '0;
      chk("clrmis_fault", 32'(fault),       32'd1);
      chk("clrmis_count", 32'(fault_count), 32'd1);

      // Reset during DP_EXEC aborts the op
      do_reset();
      req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1; req_alucont = 3'b010;
      cyc();
      req_valid = 1'b0;
      do_reset();
      chk("abort_rspv",  32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      cyc();
      chk("abort_nopulse", 32'(rsp_valid), 32'd0);

      // Randomized traffic with alternating request density
      for (int i = 0; i < 3000; i++) begin
         int dens;
         dens = ((i / 300) % 2 == 0) ? 3 : 30;
         if (i % 200 == 0) inj_xor = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
         req_valid   = ($urandom_range(0, dens - 1) == 0);
         req_a       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         req_b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         req_alucont = 3'($urandom_range(0, 7));
         scrub_en    = ($urandom_range(0, 3) != 0);
         fault_clr   = ($urandom_range(0, 39) == 0);
         reset       = ($urandom_range(0, 499) == 0);
         cyc();
      end
      reset = 1'b0; req_valid = 1'b0; fault_clr = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
